mips_pipeline_cpu: RTL and testbench
====================================

# mips_pipeline_cpu

Five-stage pipelined MIPS-subset processor core (IF, ID, EX, MEM, WB) with internal instruction memory, data memory, register file and HI/LO registers. It is the top-level DUT of the CPU bench. Instruction and data memories and the register file are preloaded hierarchically before reset release. The core forwards operands, stalls on load-use hazards and flushes on taken control transfers.

## Interface
- No parameters. Fixed sizes: instruction memory 256 bytes, data memory 256 bytes, register file 32×32 bits.
- clk  input  1  system clock; every state element updates on the rising edge.
- rst  input  1  reset, one clock; reset is asynchronous and active-low.
- Hierarchy names the bench preloads or probes (must exist with these names):
  - InstrMem.mem_array, DatMem.mem_array: byte arrays [0:255] of 8 bits, little-endian words.
  - RegFile.file_array: [0:31] of 32 bits.
  - pc: 32-bit IF-stage program counter.
  - opcode (6), funct (6), jumpoffset (26): fields of the IF/ID instruction register.
  - total_EX (2): nonzero when the IF/ID slot holds a hazard-inserted bubble.
  - rfile_wd (32): WB-stage register write data.

## Operation
- Supported instructions:
  - R-type (op 0): ADD 32, SUB 34, AND 36, OR 37, SLT 42 (signed), SLL 0 (rt<<shamt → rd), DIVU 27, MFHI 16, MFLO 18.
  - I/J-type: LW 35, SW 43, BEQ 4, BNE 5, ORI 13, J 2.
  - Any other encoding executes as NOP. All-zero word = NOP (SLL $0).
- Arithmetic:
  - ADD/SUB wrap modulo 2^32; no overflow trap.
  - ORI zero-extends imm16. LW/SW address = rs + sign-extended imm16; word access, low two address bits ignored.
  - DIVU in EX, single cycle: LO = rs/rt, HI = rs%rt, unsigned. For rt=0: LO=32'hFFFFFFFF, HI=rs.
  - MFHI/MFLO read HI/LO after any older DIVU has committed its result. A DIVU in EX forwards its result to a MFHI/MFLO immediately behind it.
- Register file:
  - $0 always reads 0; writes to $0 are discarded.
  - Written in WB. A same-cycle read of the register being written returns the new value (internal bypass).
- Control flow:
  - Branches are predicted not-taken.
  - BEQ/BNE resolve in EX. Target = PC+4 + (sext(imm16)<<2). When taken, the IF/ID and ID/EX slots are flushed to bubbles (2-cycle penalty).
  - J resolves in ID. Target = {PC+4[31:28], imm26, 2'b00}. The IF slot is flushed (1-cycle penalty).
- Hazards:
  - EX operands forward from EX/MEM (priority) or from MEM/WB when the destination matches rs/rt and is nonzero.
  - Load-use (LW in EX, consumer in ID): PC and IF/ID hold for one cycle and a bubble enters ID/EX.
  - total_EX reads 1 in the cycle a stall or flush bubble occupies IF/ID, otherwise 0.
- Reset clears:
  - pc=0, all pipeline registers (all slots NOP, total_EX=0), HI=LO=0.
  - Memories and the register file are not cleared.

## Timing
- One instruction issued per cycle when no hazard is present.
- An instruction fetched at cycle n writes back at cycle n+4. rfile_wd is valid in WB.
- SW writes memory at the rising edge ending MEM. LW data is available in WB.
- Taken branch: target is fetched 3 cycles after the branch was fetched. Jump: 2 cycles after.
- Simultaneous load-use stall and taken branch in EX: the flush wins, and the stalled consumer is squashed.
- Reset asserted mid-program: immediate return to reset state. Fetch restarts at address 0 on the first rising edge after release.

## Test plan
- Reset, then run NOPs only: pc increments 0,4,8,…; no register changes; total_EX=0.
- Dependent ALU chain:
  - Stimulus: $1=5, $2=3; ADD $3,$1,$2; SUB $4,$3,$1; SLT $5,$4,$1.
  - Required: $3=8, $4=3, $5=1, all via forwarding with no stall.
- Load-use:
  - Stimulus: data word at byte address 8 = 32'h12345678; LW $6,8($0); ORI $7,$6,0xF.
  - Required: one bubble (total_EX=1 for one cycle), then $7=32'h1234567F.
  - Follow with SW $7,12($0): data bytes 12..15 = 7F,56,34,12.
- DIVU/MFHI/MFLO:
  - Stimulus: $1=17, $2=5; DIVU $1,$2; MFLO $8; MFHI $9. Required: $8=3, $9=2.
  - Stimulus: DIVU by $0. Required: LO=FFFFFFFF, HI=dividend.
- Branches:
  - Taken BEQ $1,$1,+2: the two younger instructions are squashed and pc jumps to branch PC+12.
  - Not-taken BNE $1,$1: no penalty.
- J to 0x40: one bubble, next fetch pc=0x40.
- Write-$0 test: ADD $0,$1,$1 leaves $0=0.

Source files
------------

// File: rtl/mips_pipeline_cpu.sv
// Five-stage MIPS-subset core (IF/ID/EX/MEM/WB) with byte-wide memories, HI/LO and forwarding.
// Load-use hazards stall one cycle, J resolves in ID and taken branches resolve in EX.
module mips_pipeline_cpu (
    input logic clk,
    input logic rst
);
    typedef enum logic [3:0] {
        AluNop, AluAdd, AluSub, AluAnd, AluOr, AluSlt, AluSll, AluDivu,
        AluMfhi, AluMflo, AluLw, AluSw, AluBeq, AluBne, AluOri
    } alu_op_e;

    localparam logic [5:0] OpcR = 6'd0, OpcJ = 6'd2, OpcBeq = 6'd4, OpcBne = 6'd5,
                           OpcOri = 6'd13, OpcLw = 6'd35, OpcSw = 6'd43;

    if (1) begin : InstrMem
        logic [7:0] mem_array [0:255];
    end
    if (1) begin : DatMem
        logic [7:0] mem_array [0:255];
    end
    if (1) begin : RegFile
        logic [31:0] file_array [0:31];
    end

    logic [31:0] pc;
    logic [31:0] r_ifid_instr, r_ifid_pc4;
    logic [1:0]  total_EX;
    alu_op_e     r_ex_op;
    logic [31:0] r_ex_a, r_ex_b, r_ex_pc4;
    logic [4:0]  r_ex_rs, r_ex_rt, r_ex_dst, r_ex_shamt;
    logic [15:0] r_ex_imm;
    logic        r_ex_wen;
    logic [31:0] r_hi, r_lo;
    logic [31:0] r_mem_res, r_mem_sd;
    logic [4:0]  r_mem_dst;
    logic        r_mem_wen, r_mem_lw, r_mem_sw;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_dst;
    logic        r_wb_wen;

    logic [7:0]  w_ia;
    logic [31:0] w_if_instr;
    assign w_ia = {pc[7:2], 2'b00};
    assign w_if_instr = {InstrMem.mem_array[w_ia + 8'd3], InstrMem.mem_array[w_ia + 8'd2],
                         InstrMem.mem_array[w_ia + 8'd1], InstrMem.mem_array[w_ia]};

    logic [5:0]  opcode, funct;
    logic [25:0] jumpoffset;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [15:0] w_imm;
    assign opcode     = r_ifid_instr[31:26];
    assign w_rs       = r_ifid_instr[25:21];
    assign w_rt       = r_ifid_instr[20:16];
    assign w_rd       = r_ifid_instr[15:11];
    assign w_shamt    = r_ifid_instr[10:6];
    assign funct      = r_ifid_instr[5:0];
    assign w_imm      = r_ifid_instr[15:0];
    assign jumpoffset = r_ifid_instr[25:0];

    alu_op_e    w_id_op;
    logic [4:0] w_id_dst;
    logic       w_id_wen;
    always_comb begin
        w_id_op  = AluNop;
        w_id_dst = 5'd0;
        case (opcode)
            OpcR: begin
                w_id_dst = w_rd;
                case (funct)
                    6'd32:   w_id_op = AluAdd;
                    6'd34:   w_id_op = AluSub;
                    6'd36:   w_id_op = AluAnd;
                    6'd37:   w_id_op = AluOr;
                    6'd42:   w_id_op = AluSlt;
                    6'd0:    w_id_op = AluSll;
                    6'd27:   w_id_op = AluDivu;
                    6'd16:   w_id_op = AluMfhi;
                    6'd18:   w_id_op = AluMflo;
                    default: w_id_op = AluNop;
                endcase
            end
            OpcLw:  begin w_id_op = AluLw;  w_id_dst = w_rt; end
            OpcOri: begin w_id_op = AluOri; w_id_dst = w_rt; end
            OpcSw:  w_id_op = AluSw;
            OpcBeq: w_id_op = AluBeq;
            OpcBne: w_id_op = AluBne;
            default: w_id_op = AluNop;
        endcase
        w_id_wen = !(w_id_op inside {AluNop, AluDivu, AluSw, AluBeq, AluBne}) &&
                   (w_id_dst != 5'd0);
        if (!w_id_wen) w_id_dst = 5'd0;
    end

    // Register read with write-through from the WB stage; $0 is hardwired to zero.
    logic [31:0] w_rs_val, w_rt_val, rfile_wd;
    assign rfile_wd = r_wb_data;
    always_comb begin
        w_rs_val = RegFile.file_array[w_rs];
        w_rt_val = RegFile.file_array[w_rt];
        if (r_wb_wen && r_wb_dst == w_rs) w_rs_val = rfile_wd;
        if (r_wb_wen && r_wb_dst == w_rt) w_rt_val = rfile_wd;
        if (w_rs == 5'd0) w_rs_val = 32'd0;
        if (w_rt == 5'd0) w_rt_val = 32'd0;
    end

    logic w_uses_rs, w_uses_rt, w_stall, w_jump;
    assign w_uses_rs = (opcode != OpcJ);
    assign w_uses_rt = opcode inside {OpcR, OpcSw, OpcBeq, OpcBne};
    assign w_stall   = (r_ex_op == AluLw) && r_ex_wen &&
                       ((w_uses_rs && r_ex_dst == w_rs) || (w_uses_rt && r_ex_dst == w_rt));
    assign w_jump    = (opcode == OpcJ);

    logic [31:0] w_a, w_b, w_ex_res, w_quot, w_rem, w_br_target, w_j_target;
    logic        w_taken;
    always_comb begin
        w_a = r_ex_a;
        w_b = r_ex_b;
        if (r_wb_wen && r_wb_dst == r_ex_rs) w_a = rfile_wd;
        if (r_wb_wen && r_wb_dst == r_ex_rt) w_b = rfile_wd;
        if (r_mem_wen && r_mem_dst == r_ex_rs) w_a = r_mem_res;
        if (r_mem_wen && r_mem_dst == r_ex_rt) w_b = r_mem_res;
    end

    assign w_quot = (w_b == 32'd0) ? 32'hFFFF_FFFF : w_a / w_b;
    assign w_rem  = (w_b == 32'd0) ? w_a : w_a % w_b;

    always_comb begin
        w_ex_res = 32'd0;
        case (r_ex_op)
            AluAdd:       w_ex_res = w_a + w_b;
            AluSub:       w_ex_res = w_a - w_b;
            AluAnd:       w_ex_res = w_a & w_b;
            AluOr:        w_ex_res = w_a | w_b;
            AluSlt:       w_ex_res = {31'd0, $signed(w_a) < $signed(w_b)};
            AluSll:       w_ex_res = w_b << r_ex_shamt;
            AluMfhi:      w_ex_res = r_hi;
            AluMflo:      w_ex_res = r_lo;
            AluLw, AluSw: w_ex_res = w_a + {{16{r_ex_imm[15]}}, r_ex_imm};
            AluOri:       w_ex_res = w_a | {16'd0, r_ex_imm};
            default:      w_ex_res = 32'd0;
        endcase
    end

    assign w_taken = ((r_ex_op == AluBeq) && (w_a == w_b)) ||
                     ((r_ex_op == AluBne) && (w_a != w_b));
    assign w_br_target = r_ex_pc4 + {{14{r_ex_imm[15]}}, r_ex_imm, 2'b00};
    assign w_j_target  = {r_ifid_pc4[31:28], jumpoffset, 2'b00};

    logic [7:0]  w_da;
    logic [31:0] w_load;
    assign w_da   = {r_mem_res[7:2], 2'b00};
    assign w_load = {DatMem.mem_array[w_da + 8'd3], DatMem.mem_array[w_da + 8'd2],
                     DatMem.mem_array[w_da + 8'd1], DatMem.mem_array[w_da]};

    // Memories and register file keep their contents across reset.
    always_ff @(posedge clk) begin
        if (r_mem_sw) begin
            DatMem.mem_array[w_da]         <= r_mem_sd[7:0];
            DatMem.mem_array[w_da + 8'd1]  <= r_mem_sd[15:8];
            DatMem.mem_array[w_da + 8'd2]  <= r_mem_sd[23:16];
            DatMem.mem_array[w_da + 8'd3]  <= r_mem_sd[31:24];
        end
        if (r_wb_wen) RegFile.file_array[r_wb_dst] <= rfile_wd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc           <= 32'd0;
            r_ifid_instr <= 32'd0;
            r_ifid_pc4   <= 32'd0;
            total_EX     <= 2'd0;
            r_ex_op      <= AluNop;
            r_ex_a       <= 32'd0;
            r_ex_b       <= 32'd0;
            r_ex_pc4     <= 32'd0;
            r_ex_rs      <= 5'd0;
            r_ex_rt      <= 5'd0;
            r_ex_dst     <= 5'd0;
            r_ex_shamt   <= 5'd0;
            r_ex_imm     <= 16'd0;
            r_ex_wen     <= 1'b0;
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
            r_mem_res    <= 32'd0;
            r_mem_sd     <= 32'd0;
            r_mem_dst    <= 5'd0;
            r_mem_wen    <= 1'b0;
            r_mem_lw     <= 1'b0;
            r_mem_sw     <= 1'b0;
            r_wb_data    <= 32'd0;
            r_wb_dst     <= 5'd0;
            r_wb_wen     <= 1'b0;
        end else begin
            // A taken branch is older than anything in ID, so it overrides stall and jump.
            if (w_taken) begin
                pc           <= w_br_target;
                r_ifid_instr <= 32'd0;
                r_ifid_pc4   <= 32'd0;
                total_EX     <= 2'd1;
            end else if (w_stall) begin
                total_EX     <= 2'd1;
            end else if (w_jump) begin
                pc           <= w_j_target;
                r_ifid_instr <= 32'd0;
                r_ifid_pc4   <= 32'd0;
                total_EX     <= 2'd1;
            end else begin
                pc           <= pc + 32'd4;
                r_ifid_instr <= w_if_instr;
                r_ifid_pc4   <= pc + 32'd4;
                total_EX     <= 2'd0;
            end

            if (w_taken || w_stall) begin
                r_ex_op  <= AluNop;
                r_ex_wen <= 1'b0;
                r_ex_dst <= 5'd0;
            end else begin
                r_ex_op  <= w_id_op;
                r_ex_wen <= w_id_wen;
                r_ex_dst <= w_id_dst;
            end
            r_ex_a     <= w_rs_val;
            r_ex_b     <= w_rt_val;
            r_ex_rs    <= w_rs;
            r_ex_rt    <= w_rt;
            r_ex_shamt <= w_shamt;
            r_ex_imm   <= w_imm;
            r_ex_pc4   <= r_ifid_pc4;

            // Nothing older can squash a DIVU in EX, so HI/LO commit here and the
            // MFHI/MFLO directly behind it reads the fresh value.
            if (r_ex_op == AluDivu) begin
                r_lo <= w_quot;
                r_hi <= w_rem;
            end

            r_mem_res <= w_ex_res;
            r_mem_sd  <= w_b;
            r_mem_dst <= r_ex_dst;
            r_mem_wen <= r_ex_wen;
            r_mem_lw  <= (r_ex_op == AluLw);
            r_mem_sw  <= (r_ex_op == AluSw);

            r_wb_data <= r_mem_lw ? w_load : r_mem_res;
            r_wb_dst  <= r_mem_dst;
            r_wb_wen  <= r_mem_wen;
        end
    end
endmodule

// File: tb/tb_mips_pipeline_cpu.sv
// Directed bench for mips_pipeline_cpu: preloads memories, runs short programs and
// checks architectural state and pipeline probes with immediate assertions.
module tb_mips_pipeline_cpu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   ones = 0;

    always #5 clk = ~clk;

    mips_pipeline_cpu dut (
        .clk(clk),
        .rst(rst)
    );

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] a);
        return {6'd2, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Enter reset and clear every memory so each program starts from a known image.
    task automatic begin_test();
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) begin
            dut.InstrMem.mem_array[i] = 8'h00;
            dut.DatMem.mem_array[i]   = 8'h00;
        end
        for (int i = 0; i < 32; i++) dut.RegFile.file_array[i] = 32'd0;
    endtask

    task automatic put(input int addr, input logic [31:0] w);
        dut.InstrMem.mem_array[addr]     = w[7:0];
        dut.InstrMem.mem_array[addr + 1] = w[15:8];
        dut.InstrMem.mem_array[addr + 2] = w[23:16];
        dut.InstrMem.mem_array[addr + 3] = w[31:24];
    endtask

    task automatic setreg(input int r, input logic [31:0] v);
        dut.RegFile.file_array[r] = v;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst  = 1'b1;
        ones = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (dut.total_EX == 2'd1) ones++;
        end
    endtask

    initial begin
        // NOP-only program
        begin_test();
        setreg(1, 32'h0000_1111);
        check("rst_pc", dut.pc, 32'd0);
        check("rst_total_ex", {30'd0, dut.total_EX}, 32'd0);
        release_rst();
        for (int k = 1; k <= 4; k++) begin
            step(1);
            check("nop_pc", dut.pc, 32'(4 * k));
        end
        step(6);
        check("nop_reg1", dut.RegFile.file_array[1], 32'h0000_1111);
        check("nop_bubbles", ones, 32'd0);

        // Dependent ALU chain plus $0 write and shift/logic ops
        begin_test();
        setreg(1, 32'd5);
        setreg(2, 32'd3);
        put(0,  enc_r(5'd1, 5'd2, 5'd3,  5'd0, 6'd32));
        put(4,  enc_r(5'd3, 5'd1, 5'd4,  5'd0, 6'd34));
        put(8,  enc_r(5'd4, 5'd1, 5'd5,  5'd0, 6'd42));
        put(12, enc_r(5'd1, 5'd1, 5'd0,  5'd0, 6'd32));
        put(16, enc_r(5'd0, 5'd1, 5'd10, 5'd0, 6'd32));
        put(20, enc_r(5'd0, 5'd1, 5'd19, 5'd4, 6'd0));
        put(24, enc_r(5'd1, 5'd2, 5'd20, 5'd0, 6'd36));
        put(28, enc_r(5'd1, 5'd2, 5'd21, 5'd0, 6'd37));
        release_rst();
        step(4);
        check("alu_wb_add", dut.rfile_wd, 32'd8);
        step(1);
        check("alu_wb_sub", dut.rfile_wd, 32'd3);
        step(12);
        check("alu_add", dut.RegFile.file_array[3], 32'd8);
        check("alu_sub", dut.RegFile.file_array[4], 32'd3);
        check("alu_slt", dut.RegFile.file_array[5], 32'd1);
        check("alu_r0", dut.RegFile.file_array[0], 32'd0);
        check("alu_read_r0", dut.RegFile.file_array[10], 32'd5);
        check("alu_sll", dut.RegFile.file_array[19], 32'h50);
        check("alu_and", dut.RegFile.file_array[20], 32'd1);
        check("alu_or", dut.RegFile.file_array[21], 32'd7);
        check("alu_bubbles", ones, 32'd0);

        // Reset asserted mid-program, same image
        @(negedge clk);
        rst = 1'b0;
        #1;
        setreg(3, 32'd0);
        release_rst();
        step(3);
        check("mid_pc_before", dut.pc, 32'd12);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_pc", dut.pc, 32'd0);
        check("mid_rst_total_ex", {30'd0, dut.total_EX}, 32'd0);
        check("mid_rst_wd", dut.rfile_wd, 32'd0);
        check("mid_rst_no_wb", dut.RegFile.file_array[3], 32'd0);
        release_rst();
        step(1);
        check("mid_restart_pc", dut.pc, 32'd4);
        step(12);
        check("mid_rerun_add", dut.RegFile.file_array[3], 32'd8);

        // Load-use stall, then store
        begin_test();
        dut.DatMem.mem_array[8]  = 8'h78;
        dut.DatMem.mem_array[9]  = 8'h56;
        dut.DatMem.mem_array[10] = 8'h34;
        dut.DatMem.mem_array[11] = 8'h12;
        put(0, enc_i(6'd35, 5'd0, 5'd6, 16'd8));
        put(4, enc_i(6'd13, 5'd6, 5'd7, 16'h000F));
        put(8, enc_i(6'd43, 5'd0, 5'd7, 16'd12));
        release_rst();
        step(3);
        check("lu_pc_hold", dut.pc, 32'd8);
        check("lu_bubble", {30'd0, dut.total_EX}, 32'd1);
        step(1);
        check("lu_pc_resume", dut.pc, 32'd12);
        step(10);
        check("lu_lw", dut.RegFile.file_array[6], 32'h1234_5678);
        check("lu_ori", dut.RegFile.file_array[7], 32'h1234_567F);
        check("lu_bubble_count", ones, 32'd1);
        check("lu_sw", {dut.DatMem.mem_array[15], dut.DatMem.mem_array[14],
                        dut.DatMem.mem_array[13], dut.DatMem.mem_array[12]}, 32'h1234_567F);

        // DIVU / MFLO / MFHI, including divide by $0
        begin_test();
        setreg(1, 32'd17);
        setreg(2, 32'd5);
        put(0,  enc_r(5'd1, 5'd2, 5'd0,  5'd0, 6'd27));
        put(4,  enc_r(5'd0, 5'd0, 5'd8,  5'd0, 6'd18));
        put(8,  enc_r(5'd0, 5'd0, 5'd9,  5'd0, 6'd16));
        put(12, enc_r(5'd1, 5'd0, 5'd0,  5'd0, 6'd27));
        put(16, enc_r(5'd0, 5'd0, 5'd11, 5'd0, 6'd18));
        put(20, enc_r(5'd0, 5'd0, 5'd12, 5'd0, 6'd16));
        release_rst();
        step(12);
        check("div_lo", dut.RegFile.file_array[8], 32'd3);
        check("div_hi", dut.RegFile.file_array[9], 32'd2);
        check("div0_lo", dut.RegFile.file_array[11], 32'hFFFF_FFFF);
        check("div0_hi", dut.RegFile.file_array[12], 32'd17);
        check("div_bubbles", ones, 32'd0);

        // Not-taken BNE, then taken BEQ +2
        begin_test();
        setreg(1, 32'd5);
        put(0,  enc_i(6'd5,  5'd1, 5'd1,  16'd5));
        put(4,  enc_i(6'd13, 5'd0, 5'd13, 16'h11));
        put(8,  enc_i(6'd4,  5'd1, 5'd1,  16'd2));
        put(12, enc_i(6'd13, 5'd0, 5'd14, 16'h22));
        put(16, enc_i(6'd13, 5'd0, 5'd15, 16'h33));
        put(20, enc_i(6'd13, 5'd0, 5'd16, 16'h44));
        release_rst();
        step(2);
        check("bne_no_penalty", dut.pc, 32'd8);
        step(2);
        check("beq_pre_flush", {30'd0, dut.total_EX}, 32'd0);
        step(1);
        check("beq_target_pc", dut.pc, 32'd20);
        check("beq_flush", {30'd0, dut.total_EX}, 32'd1);
        step(9);
        check("bne_fallthru", dut.RegFile.file_array[13], 32'h11);
        check("beq_squash1", dut.RegFile.file_array[14], 32'd0);
        check("beq_squash2", dut.RegFile.file_array[15], 32'd0);
        check("beq_target", dut.RegFile.file_array[16], 32'h44);
        check("br_bubble_count", ones, 32'd1);

        // J to 0x40
        begin_test();
        put(0,    enc_j(26'h10));
        put(4,    enc_i(6'd13, 5'd0, 5'd17, 16'h55));
        put(64,   enc_i(6'd13, 5'd0, 5'd18, 16'h66));
        release_rst();
        step(1);
        check("j_opcode", {26'd0, dut.opcode}, 32'd2);
        check("j_offset", {6'd0, dut.jumpoffset}, 32'h10);
        step(1);
        check("j_pc", dut.pc, 32'h40);
        check("j_bubble", {30'd0, dut.total_EX}, 32'd1);
        step(8);
        check("j_squash", dut.RegFile.file_array[17], 32'd0);
        check("j_target", dut.RegFile.file_array[18], 32'h66);
        check("j_bubble_count", ones, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
